// File: rtl/ex_mem.sv
// EX->MEM pipeline register with bubble/hold/flush control and
// MADD/MSUB accumulator park-and-return path back to EX.
module ex_mem #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 5,
    parameter int STALL_W = 6
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [STALL_W-1:0]  stall,
    input  logic                flush,
    input  logic [ADDR_W-1:0]   ex_wd,
    input  logic                ex_wreg,
    input  logic [DATA_W-1:0]   ex_wdata,
    input  logic                ex_whilo,
    input  logic [DATA_W-1:0]   ex_hi,
    input  logic [DATA_W-1:0]   ex_lo,
    input  logic [2*DATA_W-1:0] hilo_i,
    input  logic [1:0]          cnt_i,
    output logic [ADDR_W-1:0]   mem_wd,
    output logic                mem_wreg,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic                mem_whilo,
    output logic [DATA_W-1:0]   mem_hi,
    output logic [DATA_W-1:0]   mem_lo,
    output logic [2*DATA_W-1:0] hilo_o,
    output logic [1:0]          cnt_o
);

    // Only the EX and MEM stall bits matter here.
    logic ex_stall;
    logic mem_stall;
    logic bubble;
    logic hold;
    logic unused_stall;

    assign ex_stall     = stall[3];
    assign mem_stall    = stall[4];
    assign bubble       = ex_stall & ~mem_stall;
    assign hold         = ex_stall & mem_stall;
    assign unused_stall = ^{stall[STALL_W-1:5], stall[2:0]};

    // Pipeline payload: flush beats bubble, bubble beats hold.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_wd    <= '0;
            mem_wreg  <= 1'b0;
            mem_wdata <= '0;
            mem_whilo <= 1'b0;
            mem_hi    <= '0;
            mem_lo    <= '0;
        end else if (flush || bubble) begin
            mem_wd    <= '0;
            mem_wreg  <= 1'b0;
            mem_wdata <= '0;
            mem_whilo <= 1'b0;
            mem_hi    <= '0;
            mem_lo    <= '0;
        end else if (!hold) begin
            mem_wd    <= ex_wd;
            mem_wreg  <= ex_wreg;
            mem_wdata <= ex_wdata;
            mem_whilo <= ex_whilo;
            mem_hi    <= ex_hi;
            mem_lo    <= ex_lo;
        end
    end

    // Accumulator park: captured on a bubble, dropped once EX advances.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hilo_o <= '0;
            cnt_o  <= 2'd0;
        end else if (flush) begin
            hilo_o <= '0;
            cnt_o  <= 2'd0;
        end else if (bubble) begin
            hilo_o <= hilo_i;
            cnt_o  <= cnt_i;
        end else if (!hold) begin
            hilo_o <= '0;
            cnt_o  <= 2'd0;
        end
    end

endmodule
